seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector: samples one bit per qualified clock and pulses `bout` whenever the last `PAT_W` received bits equal a runtime-loadable pattern. It extends the fixed 4-bit "1001" detector with several features:
- configurable pattern width
- runtime pattern load
- overlapping or non-overlapping match mode
- bit-valid qualifier
- saturating match counter

It sits on the serial bit stream in the SoC datapath and feeds event/interrupt logic.

---
 rtl/seq_detect_param.sv | 85 ++++++++
 tb/tb_seq_detect_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with runtime pattern load, overlap mode and saturating match counter.
// Define SEQ_BIT_MASK_EN to add the pat_mask port for per-bit don't-care compares.
module seq_detect_param #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1001,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bin,
  input  logic             bin_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_BIT_MASK_EN
  input  logic [PAT_W-1:0] pat_mask,
`endif
  output logic             bout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    ARMED
  } state_t;

  logic [PAT_W-2:0] sr;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] win;
  logic [FW-1:0]    fillNext;
  logic             hit;
  state_t           state;

`ifdef SEQ_BIT_MASK_EN
  assign mask = pat_mask;
`else
  assign mask = '1;
`endif

  // State is a view of the fill level; the register itself is fill.
  always_comb begin
    state = EMPTY;
    if (fill == FULL)
      state = ARMED;
    else if (fill != '0)
      state = FILLING;
  end

  always_comb begin
    win      = {sr, bin};
    fillNext = (state == ARMED) ? FULL : fill + 1'b1;
    hit      = (fillNext == FULL) && (((win ^ pat) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      fill      <= '0;
      pat       <= PAT_RST;
      bout      <= 1'b0;
      match_cnt <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      sr   <= '0;
      fill <= '0;
      bout <= 1'b0;
    end else if (bin_valid) begin
      sr   <= win[PAT_W-2:0];
      bout <= hit;
      // Non-overlapping mode restarts the history so matches cannot share bits.
      fill <= (hit && !overlap) ? '0 : fillNext;
      if (hit && (match_cnt != '1))
        match_cnt <= match_cnt + 1'b1;
    end else begin
      bout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a default instance plus a CNT_W=2 all-ones instance for saturation.
// Mask checks run only when SEQ_BIT_MASK_EN is defined.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bin = 1'b0;
  logic       bin_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
`ifdef SEQ_BIT_MASK_EN
  logic [3:0] pat_mask = 4'b1111;
`endif
  logic       bout;
  logic [7:0] match_cnt;
  logic       boutSat;
  logic [1:0] matchCntSat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .reset(reset), .bin(bin), .bin_valid(bin_valid),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_BIT_MASK_EN
    .pat_mask(pat_mask),
`endif
    .bout(bout), .match_cnt(match_cnt)
  );

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1111), .CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .bin(bin), .bin_valid(bin_valid),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_BIT_MASK_EN
    .pat_mask(pat_mask),
`endif
    .bout(boutSat), .match_cnt(matchCntSat)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       vld;
    logic       b;
    logic       ovl;
    logic       ld;
    logic [3:0] pin;
    logic       expBout;
    logic [7:0] expCnt;
    logic       sat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic rst, logic vld, logic b, logic ovl,
                              logic ld, logic [3:0] pin, logic eb, logic [7:0] ec, logic sat);
    vec_t v;
    v.name = name; v.rst = rst; v.vld = vld; v.b = b; v.ovl = ovl;
    v.ld = ld; v.pin = pin; v.expBout = eb; v.expCnt = ec; v.sat = sat;
    vecs.push_back(v);
  endfunction

  // Inputs change after the edge; outputs are sampled 1 time unit after the next edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic b,
                               input logic ovl, input logic ld, input logic [3:0] pin);
    reset = rst; bin_valid = vld; bin = b; overlap = ovl; pat_load = ld; pat_in = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eb, input logic [7:0] ec, input logic sat);
    logic       ab;
    logic [7:0] ac;
    ab = sat ? boutSat : bout;
    ac = sat ? {6'd0, matchCntSat} : match_cnt;
    checks++;
    if (ab !== eb || ac !== ec) begin
      failures++;
      $display("[TB] FAIL %s: bout=%0b match_cnt=%0d, expected bout=%0b match_cnt=%0d",
               name, ab, ac, eb, ec);
    end
  endtask

  initial begin
    // reset
    add("reset",   1,0,0,1,0,4'h0, 0,0,0);
    // overlap=1, 1001001 -> pulses after bits 4 and 7
    add("ovl1.b1", 0,1,1,1,0,4'h0, 0,0,0);
    add("ovl1.b2", 0,1,0,1,0,4'h0, 0,0,0);
    add("ovl1.b3", 0,1,0,1,0,4'h0, 0,0,0);
    add("ovl1.b4", 0,1,1,1,0,4'h0, 1,1,0);
    add("ovl1.b5", 0,1,0,1,0,4'h0, 0,1,0);
    add("ovl1.b6", 0,1,0,1,0,4'h0, 0,1,0);
    add("ovl1.b7", 0,1,1,1,0,4'h0, 1,2,0);
    // overlap=0, same stream -> single pulse
    add("ovl0.rst",1,0,0,0,0,4'h0, 0,0,0);
    add("ovl0.b1", 0,1,1,0,0,4'h0, 0,0,0);
    add("ovl0.b2", 0,1,0,0,0,4'h0, 0,0,0);
    add("ovl0.b3", 0,1,0,0,0,4'h0, 0,0,0);
    add("ovl0.b4", 0,1,1,0,0,4'h0, 1,1,0);
    add("ovl0.b5", 0,1,0,0,0,4'h0, 0,1,0);
    add("ovl0.b6", 0,1,0,0,0,4'h0, 0,1,0);
    add("ovl0.b7", 0,1,1,0,0,4'h0, 0,1,0);
    // gaps in bin_valid stretch the stream
    add("gap.rst", 1,0,0,1,0,4'h0, 0,0,0);
    add("gap.b1",  0,1,1,1,0,4'h0, 0,0,0);
    for (int i = 0; i < 3; i++) add("gap.idle1", 0,0,1,1,0,4'h0, 0,0,0);
    add("gap.b2",  0,1,0,1,0,4'h0, 0,0,0);
    for (int i = 0; i < 3; i++) add("gap.idle2", 0,0,1,1,0,4'h0, 0,0,0);
    add("gap.b3",  0,1,0,1,0,4'h0, 0,0,0);
    for (int i = 0; i < 3; i++) add("gap.idle3", 0,0,1,1,0,4'h0, 0,0,0);
    add("gap.b4",  0,1,1,1,0,4'h0, 1,1,0);
    add("gap.post",0,0,1,1,0,4'h0, 0,1,0);
    // pattern load mid-stream, simultaneous bit dropped
    add("ld.rst",  1,0,0,1,0,4'h0, 0,0,0);
    add("ld.b1",   0,1,1,1,0,4'h0, 0,0,0);
    add("ld.b2",   0,1,1,1,0,4'h0, 0,0,0);
    add("ld.load", 0,1,1,1,1,4'hC, 0,0,0);
    add("ld.n1",   0,1,1,1,0,4'h0, 0,0,0);
    add("ld.n2",   0,1,1,1,0,4'h0, 0,0,0);
    add("ld.n3",   0,1,0,1,0,4'h0, 0,0,0);
    add("ld.n4",   0,1,0,1,0,4'h0, 1,1,0);
    add("ld.n5",   0,1,1,1,0,4'h0, 0,1,0);
    add("ld.hold", 0,0,1,1,1,4'h9, 0,1,0);
    // CNT_W=2, all-ones pattern: back-to-back pulses, counter saturates at 3
    add("sat.rst", 1,0,0,1,0,4'h0, 0,0,1);
    add("sat.b1",  0,1,1,1,0,4'h0, 0,0,1);
    add("sat.b2",  0,1,1,1,0,4'h0, 0,0,1);
    add("sat.b3",  0,1,1,1,0,4'h0, 0,0,1);
    add("sat.b4",  0,1,1,1,0,4'h0, 1,1,1);
    add("sat.b5",  0,1,1,1,0,4'h0, 1,2,1);
    add("sat.b6",  0,1,1,1,0,4'h0, 1,3,1);
    add("sat.b7",  0,1,1,1,0,4'h0, 1,3,1);
    add("sat.b8",  0,1,1,1,0,4'h0, 1,3,1);
    add("sat.idle",0,0,1,1,0,4'h0, 0,3,1);

    $display("[TB] running %0d table vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].b, vecs[i].ovl, vecs[i].ld, vecs[i].pin);
      checkOutput(vecs[i].name, vecs[i].expBout, vecs[i].expCnt, vecs[i].sat);
    end

    // Reset mid-stream discards history; reset also wins over a simultaneous load.
    applyStimulus(1,0,0,1,0,4'h0);
    applyStimulus(0,1,1,1,0,4'h0);
    applyStimulus(0,1,0,1,0,4'h0);
    applyStimulus(0,1,0,1,0,4'h0);
    applyStimulus(1,1,1,1,1,4'h0);
    checkOutput("midrst.reset", 0, 0, 0);
    applyStimulus(0,1,1,1,0,4'h0);
    checkOutput("midrst.b1", 0, 0, 0);
    applyStimulus(0,1,0,1,0,4'h0);
    applyStimulus(0,1,0,1,0,4'h0);
    checkOutput("midrst.b3", 0, 0, 0);
    applyStimulus(0,1,1,1,0,4'h0);
    checkOutput("midrst.fresh4", 1, 1, 0);

    // Switching overlap off mid-stream only affects the next hit.
    applyStimulus(0,1,0,0,0,4'h0);
    applyStimulus(0,1,0,0,0,4'h0);
    applyStimulus(0,1,1,0,0,4'h0);
    checkOutput("ovlswitch.hit", 1, 2, 0);
    applyStimulus(0,1,0,0,0,4'h0);
    applyStimulus(0,1,0,0,0,4'h0);
    applyStimulus(0,1,1,0,0,4'h0);
    checkOutput("ovlswitch.nohit", 0, 2, 0);

`ifdef SEQ_BIT_MASK_EN
    applyStimulus(1,0,0,1,0,4'h0);
    pat_mask = 4'b1001;
    applyStimulus(0,0,0,1,1,4'h9);
    applyStimulus(0,1,1,1,0,4'h0);
    applyStimulus(0,1,1,1,0,4'h0);
    applyStimulus(0,1,1,1,0,4'h0);
    checkOutput("mask.b3", 0, 0, 0);
    applyStimulus(0,1,1,1,0,4'h0);
    checkOutput("mask.hit", 1, 1, 0);
    pat_mask = 4'b1111;
    applyStimulus(0,1,1,1,0,4'h0);
    checkOutput("mask.exact", 0, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
